// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage and its decoder.
package alu_issue_stage_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REGAW     = 5;
   localparam int unsigned ILEN      = 32;
   localparam int unsigned ALU_SEL_W = 4;

   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SRL  = 4'd3,
      ALU_SRA  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_NOP  = 4'd10
   } alu_sel_e;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HALF  = 2'd1,
      S_FULL  = 2'd2
   } issue_state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_sel_e               alu_sel;
      logic [XLEN-1:0]        op1;
      logic [XLEN-1:0]        op2;
      logic [REGAW-1:0]       rd;
      logic                   wb_en;
      logic                   illegal;
      logic [XLEN-1:0]        pc;
   } issue_entry_t;

   localparam int unsigned ENTRY_W = $bits(issue_entry_t);

   // Base funct3 -> ALU op map (SUB/SRA are selected by funct7 on top of this)
   function automatic alu_sel_e f3_to_sel(input logic [2:0] f3);
      alu_sel_e sel;
      case (f3)
         F3_ADD:  sel = ALU_ADD;
         F3_SLL:  sel = ALU_SLL;
         F3_SLT:  sel = ALU_SLT;
         F3_SLTU: sel = ALU_SLTU;
         F3_XOR:  sel = ALU_XOR;
         F3_SR:   sel = ALU_SRL;
         F3_OR:   sel = ALU_OR;
         F3_AND:  sel = ALU_AND;
         default: sel = ALU_NOP;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Fetch-side and execute-side handshake bundle of the ALU issue stage.
interface alu_issue_stage_if;
   import alu_issue_stage_pkg::*;

   logic                 flush;
   logic                 if_valid;
   logic                 if_ready;
   logic [ILEN-1:0]      if_instr;
   logic [XLEN-1:0]      if_pc;
   logic [REGAW-1:0]     rs1_addr;
   logic [REGAW-1:0]     rs2_addr;
   logic [XLEN-1:0]      rs1_data;
   logic [XLEN-1:0]      rs2_data;
   logic                 ex_valid;
   logic                 ex_ready;
   logic [ALU_SEL_W-1:0] ex_alu_sel;
   logic [XLEN-1:0]      ex_op1;
   logic [XLEN-1:0]      ex_op2;
   logic [REGAW-1:0]     ex_rd;
   logic                 ex_wb_en;
   logic                 ex_illegal;
   logic [XLEN-1:0]      ex_pc;

   // Environment view: fetch, regfile and execute unit
   modport master (
      output flush, if_valid, if_instr, if_pc, rs1_data, rs2_data, ex_ready,
      input  if_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_sel, ex_op1, ex_op2,
             ex_rd, ex_wb_en, ex_illegal, ex_pc
   );

   // Issue stage view
   modport slave (
      input  flush, if_valid, if_instr, if_pc, rs1_data, rs2_data, ex_ready,
      output if_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_sel, ex_op1, ex_op2,
             ex_rd, ex_wb_en, ex_illegal, ex_pc
   );

endinterface

// File: rtl/rv32i_alu_decode.sv
// Combinational RV32I ALU-class decoder: instruction + pc + rs data -> issue entry.
module rv32i_alu_decode
   import alu_issue_stage_pkg::*;
(
   input  logic [ILEN-1:0]  i_instr,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_rs1_data,
   input  logic [XLEN-1:0]  i_rs2_data,
   output issue_entry_t     o_entry_c
);

   logic [6:0]       w_opcode;
   logic [2:0]       w_f3;
   logic [6:0]       w_f7;
   logic [REGAW-1:0] w_rd;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_imm_u;
   logic [XLEN-1:0]  w_shamt;

   assign w_opcode = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];
   assign w_rd     = i_instr[11:7];
   assign w_imm_i  = XLEN'($signed(i_instr[31:20]));
   assign w_imm_u  = XLEN'({i_instr[31:12], 12'b0});
   assign w_shamt  = XLEN'(i_instr[24:20]);

   alu_sel_e        w_sel;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   logic            w_legal;

   // Opcode/funct decode; anything not legal collapses to a NOP with zero operands
   always_comb begin
      w_sel   = ALU_NOP;
      w_op1   = '0;
      w_op2   = '0;
      w_legal = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            w_op1   = i_rs1_data;
            w_op2   = i_rs2_data;
            w_sel   = f3_to_sel(w_f3);
            w_legal = (w_f7 == F7_ZERO);
            if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
               w_sel   = ALU_SUB;
               w_legal = 1'b1;
            end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
               w_sel   = ALU_SRA;
               w_legal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            w_op1   = i_rs1_data;
            w_op2   = w_imm_i;
            w_sel   = f3_to_sel(w_f3);
            w_legal = 1'b1;
            if (w_f3 == F3_SLL) begin
               w_op2   = w_shamt;
               w_legal = (w_f7 == F7_ZERO);
            end else if (w_f3 == F3_SR) begin
               w_op2   = w_shamt;
               if (w_f7 == F7_ALT) begin
                  w_sel = ALU_SRA;
               end
               w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
            end
         end
         OPC_LUI: begin
            w_sel   = ALU_NOP;
            w_op2   = w_imm_u;
            w_legal = 1'b1;
         end
         OPC_AUIPC: begin
            w_sel   = ALU_ADD;
            w_op1   = i_pc;
            w_op2   = w_imm_u;
            w_legal = 1'b1;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
      if (!w_legal) begin
         w_sel = ALU_NOP;
         w_op1 = '0;
         w_op2 = '0;
      end
   end

   // Assemble the issue entry
   always_comb begin
      o_entry_c         = '0;
      o_entry_c.alu_sel = w_sel;
      o_entry_c.op1     = w_op1;
      o_entry_c.op2     = w_op2;
      o_entry_c.rd      = w_rd;
      o_entry_c.wb_en   = w_legal && (w_rd != '0);
      o_entry_c.illegal = !w_legal;
      o_entry_c.pc      = i_pc;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes fetched instructions into a main/skid buffer pair
// so the fetch-side ready can come straight from a flop.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   alu_issue_stage_if.slave    io_bus
);

   issue_state_e       r_state;
   issue_entry_t       r_main;
   logic [ENTRY_W-1:0] r_skid;
   logic               r_if_ready;
   logic               r_ex_valid;

   issue_entry_t       w_dec;
   logic               w_in;
   logic               w_out;

   assign io_bus.rs1_addr = io_bus.if_instr[19:15];
   assign io_bus.rs2_addr = io_bus.if_instr[24:20];

   rv32i_alu_decode u_decode (
      .i_instr    (io_bus.if_instr),
      .i_pc       (io_bus.if_pc),
      .i_rs1_data (io_bus.rs1_data),
      .i_rs2_data (io_bus.rs2_data),
      .o_entry_c  (w_dec)
   );

   assign w_in  = io_bus.if_valid && r_if_ready && !io_bus.flush;
   assign w_out = r_ex_valid && io_bus.ex_ready;

   // Occupancy FSM with main/skid registers; flush beats any transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_EMPTY;
         r_main     <= '0;
         r_skid     <= '0;
         r_if_ready <= 1'b0;
         r_ex_valid <= 1'b0;
      end else if (io_bus.flush) begin
         r_state    <= S_EMPTY;
         r_main     <= '0;
         r_skid     <= '0;
         r_if_ready <= 1'b1;
         r_ex_valid <= 1'b0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               r_if_ready <= 1'b1;
               if (w_in) begin
                  r_main     <= w_dec;
                  r_state    <= S_HALF;
                  r_ex_valid <= 1'b1;
               end
            end
            S_HALF: begin
               if (w_in && !w_out) begin
                  r_skid     <= w_dec;
                  r_state    <= S_FULL;
                  r_if_ready <= 1'b0;
               end else if (!w_in && w_out) begin
                  r_state    <= S_EMPTY;
                  r_ex_valid <= 1'b0;
                  r_if_ready <= 1'b1;
               end else begin
                  if (w_in) begin
                     r_main <= w_dec;
                  end
                  r_if_ready <= 1'b1;
               end
            end
            S_FULL: begin
               if (w_out) begin
                  r_main     <= issue_entry_t'(r_skid);
                  r_state    <= S_HALF;
                  r_if_ready <= 1'b1;
               end else begin
                  r_if_ready <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_EMPTY;
               r_ex_valid <= 1'b0;
               r_if_ready <= 1'b1;
            end
         endcase
      end
   end

   assign io_bus.if_ready   = r_if_ready;
   assign io_bus.ex_valid   = r_ex_valid;
   assign io_bus.ex_alu_sel = r_main.alu_sel;
   assign io_bus.ex_op1     = r_main.op1;
   assign io_bus.ex_op2     = r_main.op2;
   assign io_bus.ex_rd      = r_main.rd;
   assign io_bus.ex_wb_en   = r_main.wb_en;
   assign io_bus.ex_illegal = r_main.illegal;
   assign io_bus.ex_pc      = r_main.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, flush, async reset.
module tb_alu_issue_stage;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   alu_issue_stage_if bus();

   alu_issue_stage dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Regfile model: x0=0, x1=10, x2=3, others 100+index
   function automatic logic [31:0] reg_val(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (a == 5'd1) return 32'd10;
      if (a == 5'd2) return 32'd3;
      return 32'd100 + 32'(a);
   endfunction

   assign bus.rs1_data = reg_val(bus.rs1_addr);
   assign bus.rs2_data = reg_val(bus.rs2_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      bus.if_valid = v;
      bus.if_instr = instr;
      bus.if_pc    = pc;
   endtask

   task automatic check_entry(input string tag, input logic [3:0] sel, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [4:0] rd, input logic wb,
                              input logic ill);
      check({tag, ".valid"}, 32'(bus.ex_valid), 32'd1);
      check({tag, ".sel"},   32'(bus.ex_alu_sel), 32'(sel));
      check({tag, ".op1"},   bus.ex_op1, op1);
      check({tag, ".op2"},   bus.ex_op2, op2);
      check({tag, ".rd"},    32'(bus.ex_rd), 32'(rd));
      check({tag, ".wb"},    32'(bus.ex_wb_en), 32'(wb));
      check({tag, ".ill"},   32'(bus.ex_illegal), 32'(ill));
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);

      // Reset values
      #12;
      check("rst.if_ready", 32'(bus.if_ready), 32'd0);
      check("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
      check("rst.ex_op1",   bus.ex_op1, 32'd0);
      check("rst.ex_pc",    bus.ex_pc, 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst.if_ready", 32'(bus.if_ready), 32'd1);
      check("post_rst.ex_valid", 32'(bus.ex_valid), 32'd0);

      // Streaming decode vectors with ex_ready=1
      bus.ex_ready = 1'b1;
      drive(1'b1, 32'h402081B3, 32'h100);            // SUB x3,x1,x2
      check("rs1_addr", 32'(bus.rs1_addr), 32'd1);
      check("rs2_addr", 32'(bus.rs2_addr), 32'd2);
      tick();
      check_entry("sub", 4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);
      check("sub.pc", bus.ex_pc, 32'h100);
      drive(1'b1, 32'hFFF00293, 32'h104);            // ADDI x5,x0,-1
      tick();
      check_entry("addi", 4'd0, 32'd0, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
      drive(1'b1, 32'h40315093, 32'h108);            // SRAI x1,x2,3
      tick();
      check_entry("srai", 4'd4, 32'd3, 32'd3, 5'd1, 1'b1, 1'b0);
      drive(1'b1, 32'h123453B7, 32'h10C);            // LUI x7,0x12345
      tick();
      check_entry("lui", 4'd10, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
      drive(1'b1, 32'h00001217, 32'h200);            // AUIPC x4,0x1
      tick();
      check_entry("auipc", 4'd0, 32'h200, 32'h1000, 5'd4, 1'b1, 1'b0);
      drive(1'b1, 32'h0020B333, 32'h204);            // SLTU x6,x1,x2
      tick();
      check_entry("sltu", 4'd6, 32'd10, 32'd3, 5'd6, 1'b1, 1'b0);
      drive(1'b1, 32'h022081B3, 32'h208);            // funct7=0000001 on OP: illegal
      tick();
      check_entry("badf7", 4'd10, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
      drive(1'b1, 32'h00000000, 32'h20C);            // all-zero word: illegal
      tick();
      check_entry("zero", 4'd10, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("drain.ex_valid", 32'(bus.ex_valid), 32'd0);

      // Backpressure: three offered, two held, in-order release
      bus.ex_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h300);            // ADDI x1,x0,1
      tick();
      check("bp1.op2", bus.ex_op2, 32'd1);
      check("bp1.if_ready", 32'(bus.if_ready), 32'd1);
      drive(1'b1, 32'h00200113, 32'h304);            // ADDI x2,x0,2
      tick();
      check("bp2.if_ready", 32'(bus.if_ready), 32'd0);
      check("bp2.op2_hold", bus.ex_op2, 32'd1);
      drive(1'b1, 32'h00300193, 32'h308);            // ADDI x3,x0,3
      tick();
      check("bp3.if_ready", 32'(bus.if_ready), 32'd0);
      check("bp3.op2_hold", bus.ex_op2, 32'd1);
      check("bp3.rd_hold",  32'(bus.ex_rd), 32'd1);
      check("bp3.pc_hold",  bus.ex_pc, 32'h300);
      bus.ex_ready = 1'b1;
      tick();
      check("rel1.op2", bus.ex_op2, 32'd2);
      check("rel1.rd",  32'(bus.ex_rd), 32'd2);
      check("rel1.if_ready", 32'(bus.if_ready), 32'd1);
      tick();
      check("rel2.op2", bus.ex_op2, 32'd3);
      check("rel2.rd",  32'(bus.ex_rd), 32'd3);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("rel3.ex_valid", 32'(bus.ex_valid), 32'd0);

      // Flush while FULL
      bus.ex_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h400);
      tick();
      drive(1'b1, 32'h00200113, 32'h404);
      tick();
      check("full.if_ready", 32'(bus.if_ready), 32'd0);
      bus.flush = 1'b1;
      drive(1'b1, 32'h00300193, 32'h408);
      tick();
      bus.flush = 1'b0;
      check("flf.ex_valid", 32'(bus.ex_valid), 32'd0);
      check("flf.if_ready", 32'(bus.if_ready), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("flf.no_capture", 32'(bus.ex_valid), 32'd0);

      // Flush while HALF must also block the offered instruction
      drive(1'b1, 32'h00100093, 32'h500);
      tick();
      check("half.ex_valid", 32'(bus.ex_valid), 32'd1);
      bus.flush = 1'b1;
      drive(1'b1, 32'h00200113, 32'h504);
      tick();
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("flh.ex_valid", 32'(bus.ex_valid), 32'd0);
      tick();
      check("flh.no_capture", 32'(bus.ex_valid), 32'd0);

      // Async reset mid-stream
      drive(1'b1, 32'h00100093, 32'h600);
      tick();
      check("pre_arst.ex_valid", 32'(bus.ex_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.ex_valid", 32'(bus.ex_valid), 32'd0);
      check("arst.ex_op2",   bus.ex_op2, 32'd0);
      check("arst.if_ready", 32'(bus.if_ready), 32'd0);
      drive(1'b0, 32'h0, 32'h0);
      #3;
      rst_n = 1'b1;
      tick();
      check("arst_rel.if_ready", 32'(bus.if_ready), 32'd1);
      bus.ex_ready = 1'b1;
      drive(1'b1, 32'h402081B3, 32'h700);
      tick();
      check_entry("arst_sub", 4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
